// File: rtl/chronos_pkg.sv
// Shared chronos definitions: OCL error return words, tile component IDs
// and the state encoding of the per-tile OCL register slave.
package chronos_pkg;

  localparam logic [31:0] OCL_BAD_ADDR_DATA = 32'hDEADDEAD;
  localparam logic [31:0] OCL_TIMEOUT_DATA  = 32'hDEADBEEF;

  // Component IDs as carried in address bits [15:8]
  localparam logic [7:0] ID_TASK_UNIT  = 8'd0;
  localparam logic [7:0] ID_COALESCER  = 8'd1;
  localparam logic [7:0] ID_CQ         = 8'd2;
  localparam logic [7:0] ID_L2         = 8'd3;
  localparam logic [7:0] ID_SPLITTER   = 8'd4;
  localparam logic [7:0] ID_UNDO_LOG   = 8'd5;
  localparam logic [7:0] ID_SERIALIZER = 8'd6;
  localparam logic [7:0] ID_CORE_BASE  = 8'd8;

  typedef enum logic [2:0] {
    OCL_IDLE,
    OCL_W_WAIT,
    OCL_W_ISSUE,
    OCL_B_SEND,
    OCL_R_ISSUE,
    OCL_R_WAIT,
    OCL_R_SEND
  } tile_ocl_state_t;

endpackage

// File: rtl/tile_ocl_slave.sv
// Per-tile OCL endpoint: decodes component ID / register offset from single-beat
// OCL transactions and drives a one-cycle register strobe bus to the tile components.
module tile_ocl_slave
  import chronos_pkg::*;
#(
  parameter int N_COMP       = 16,
  parameter int READ_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rstn,

  input  logic                   ocl_awvalid,
  output logic                   ocl_awready,
  input  logic [31:0]            ocl_awaddr,
  input  logic                   ocl_wvalid,
  output logic                   ocl_wready,
  input  logic [31:0]            ocl_wdata,
  output logic                   ocl_bvalid,
  input  logic                   ocl_bready,

  input  logic                   ocl_arvalid,
  output logic                   ocl_arready,
  input  logic [31:0]            ocl_araddr,
  output logic                   ocl_rvalid,
  output logic [31:0]            ocl_rdata,
  input  logic                   ocl_rready,

  output logic [N_COMP-1:0]      reg_wvalid,
  output logic [7:0]             reg_waddr,
  output logic [31:0]            reg_wdata,
  output logic [N_COMP-1:0]      reg_arvalid,
  output logic [7:0]             reg_araddr,
  input  logic [N_COMP-1:0]      reg_rvalid,
  input  logic [N_COMP*32-1:0]   reg_rdata
);

  localparam int CW = $clog2(READ_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_TIMEOUT - 1);

  tile_ocl_state_t   state;
  logic [7:0]        id;
  logic [7:0]        off;
  logic [CW-1:0]     cnt;

  logic [N_COMP-1:0] id_onehot;
  logic [N_COMP-1:0] ar_onehot;
  logic              id_ok;
  logic              sel_rvalid;
  logic [31:0]       sel_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{ocl_awaddr[31:16], ocl_araddr[31:16]};

  // An out-of-range ID decodes to an all-zero one-hot, which suppresses every strobe
  always_comb begin
    id_onehot  = '0;
    ar_onehot  = '0;
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int unsigned i = 0; i < N_COMP; i++) begin
      if (ocl_araddr[15:8] == 8'(i)) ar_onehot[i] = 1'b1;
      if (id == 8'(i)) begin
        id_onehot[i] = 1'b1;
        sel_rvalid   = reg_rvalid[i];
        sel_rdata    = reg_rdata[i*32 +: 32];
      end
    end
  end

  assign id_ok = |id_onehot;

  // Address readies are gated by rstn so they read 0 throughout reset
  assign ocl_awready = rstn && (state == OCL_IDLE);
  assign ocl_arready = rstn && (state == OCL_IDLE);
  assign ocl_wready  = (state == OCL_W_WAIT);
  assign ocl_bvalid  = (state == OCL_B_SEND);
  assign ocl_rvalid  = (state == OCL_R_SEND);
  assign reg_waddr   = off;
  assign reg_araddr  = off;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= OCL_IDLE;
      id          <= '0;
      off         <= '0;
      cnt         <= '0;
      ocl_rdata   <= '0;
      reg_wdata   <= '0;
      reg_wvalid  <= '0;
      reg_arvalid <= '0;
    end else begin
      reg_wvalid  <= '0;
      reg_arvalid <= '0;
      case (state)
        OCL_IDLE: begin
          if (ocl_awvalid) begin
            id    <= ocl_awaddr[15:8];
            off   <= ocl_awaddr[7:0];
            state <= OCL_W_WAIT;
          end else if (ocl_arvalid) begin
            id          <= ocl_araddr[15:8];
            off         <= ocl_araddr[7:0];
            reg_arvalid <= ar_onehot;
            state       <= OCL_R_ISSUE;
          end
        end
        OCL_W_WAIT: begin
          if (ocl_wvalid) begin
            reg_wdata  <= ocl_wdata;
            reg_wvalid <= id_onehot;
            state      <= OCL_W_ISSUE;
          end
        end
        OCL_W_ISSUE: state <= OCL_B_SEND;
        OCL_B_SEND: begin
          if (ocl_bready) state <= OCL_IDLE;
        end
        OCL_R_ISSUE: begin
          cnt <= '0;
          if (id_ok) begin
            state <= OCL_R_WAIT;
          end else begin
            ocl_rdata <= OCL_BAD_ADDR_DATA;
            state     <= OCL_R_SEND;
          end
        end
        OCL_R_WAIT: begin
          if (sel_rvalid) begin
            ocl_rdata <= sel_rdata;
            state     <= OCL_R_SEND;
          end else if (cnt == CNT_LAST) begin
            ocl_rdata <= OCL_TIMEOUT_DATA;
            state     <= OCL_R_SEND;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        OCL_R_SEND: begin
          if (ocl_rready) state <= OCL_IDLE;
        end
        default: state <= OCL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_ocl_slave.sv
// Scoreboard bench for tile_ocl_slave: stimulus tasks queue expected register-bus
// strobes and OCL responses with their cycle; a negedge monitor pops and compares.
module tb_tile_ocl_slave;
  import chronos_pkg::*;

  localparam int N_COMP       = 16;
  localparam int READ_TIMEOUT = 64;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 ocl_awvalid = 1'b0, ocl_awready;
  logic [31:0]          ocl_awaddr = '0;
  logic                 ocl_wvalid = 1'b0, ocl_wready;
  logic [31:0]          ocl_wdata = '0;
  logic                 ocl_bvalid, ocl_bready = 1'b0;
  logic                 ocl_arvalid = 1'b0, ocl_arready;
  logic [31:0]          ocl_araddr = '0;
  logic                 ocl_rvalid, ocl_rready = 1'b0;
  logic [31:0]          ocl_rdata;
  logic [N_COMP-1:0]    reg_wvalid, reg_arvalid;
  logic [7:0]           reg_waddr, reg_araddr;
  logic [31:0]          reg_wdata;
  logic [N_COMP-1:0]    reg_rvalid = '0;
  logic [N_COMP*32-1:0] reg_rdata = '0;

  tile_ocl_slave #(.N_COMP(N_COMP), .READ_TIMEOUT(READ_TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .ocl_awvalid(ocl_awvalid), .ocl_awready(ocl_awready), .ocl_awaddr(ocl_awaddr),
    .ocl_wvalid(ocl_wvalid), .ocl_wready(ocl_wready), .ocl_wdata(ocl_wdata),
    .ocl_bvalid(ocl_bvalid), .ocl_bready(ocl_bready),
    .ocl_arvalid(ocl_arvalid), .ocl_arready(ocl_arready), .ocl_araddr(ocl_araddr),
    .ocl_rvalid(ocl_rvalid), .ocl_rdata(ocl_rdata), .ocl_rready(ocl_rready),
    .reg_wvalid(reg_wvalid), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_arvalid(reg_arvalid), .reg_araddr(reg_araddr),
    .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_WSTB, EV_RSTB, EV_B, EV_R} ev_t;
  typedef struct {
    ev_t               kind;
    int                cyc;
    logic [N_COMP-1:0] vec;
    logic [7:0]        addr;
    logic [31:0]       data;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void check32(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic logic sig(int which);
    case (which)
      0:       return ocl_awready;
      1:       return ocl_arready;
      2:       return ocl_wready;
      3:       return ocl_bvalid;
      default: return ocl_rvalid;
    endcase
  endfunction

  task automatic wait_hi(input int which, input string name);
    int n = 0;
    while (!sig(which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s_wait: got 0 for 200 cycles expected 1", name);
    end
  endtask

  logic [31:0] r_hold = '0;
  logic        prev_b = 1'b0, prev_r = 1'b0;

  task automatic match(input ev_t k, input logic [N_COMP-1:0] vec, input logic [7:0] addr,
                       input logic [31:0] data);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_%s: got event at cycle %0d expected none", k.name(), cyc);
      return;
    end
    e = q.pop_front();
    check32($sformatf("%s_kind", k.name()), 32'(k), 32'(e.kind));
    check32($sformatf("%s_cycle", k.name()), cyc, e.cyc);
    case (k)
      EV_WSTB: begin
        check32("WSTB_vec", 32'(vec), 32'(e.vec));
        check32("WSTB_addr", 32'(addr), 32'(e.addr));
        check32("WSTB_data", data, e.data);
      end
      EV_RSTB: begin
        check32("RSTB_vec", 32'(vec), 32'(e.vec));
        check32("RSTB_addr", 32'(addr), 32'(e.addr));
      end
      EV_R: begin
        check32("R_data", data, e.data);
        r_hold = e.data;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (reg_wvalid != '0) match(EV_WSTB, reg_wvalid, reg_waddr, reg_wdata);
    if (reg_arvalid != '0) match(EV_RSTB, reg_arvalid, reg_araddr, '0);
    if (ocl_bvalid && !prev_b) match(EV_B, '0, '0, '0);
    if (ocl_rvalid && !prev_r) match(EV_R, '0, '0, ocl_rdata);
    else if (ocl_rvalid && prev_r) check32("R_hold", ocl_rdata, r_hold);
    prev_b = ocl_bvalid;
    prev_r = ocl_rvalid;
  end

  // All tasks start and end on a negedge
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [N_COMP-1:0] vec, input int bdelay);
    int   hs;
    exp_t e;
    ocl_awvalid = 1'b1;
    ocl_awaddr  = a;
    wait_hi(0, "awready");
    @(posedge clk); #1;
    ocl_awvalid = 1'b0;
    hs = cyc;
    if (vec != '0) begin
      e = '{EV_WSTB, hs + 1, vec, a[7:0], d};
      q.push_back(e);
    end
    e = '{EV_B, hs + 2, '0, '0, '0};
    q.push_back(e);
    ocl_wvalid = 1'b1;
    ocl_wdata  = d;
    @(negedge clk);
    wait_hi(2, "wready");
    @(posedge clk); #1;
    ocl_wvalid = 1'b0;
    @(negedge clk);
    wait_hi(3, "bvalid");
    repeat (bdelay) @(negedge clk);
    if (bdelay > 0) check32("b_hold", {31'b0, ocl_bvalid}, 32'd1);
    ocl_bready = 1'b1;
    @(posedge clk); #1;
    ocl_bready = 1'b0;
    @(negedge clk);
  endtask

  // d = cycles from strobe to component answer (0: never answers)
  task automatic do_read(input logic [31:0] a, input logic [N_COMP-1:0] vec, input int d,
                         input logic [31:0] rd, input int lat, input logic [31:0] exp_data,
                         input int rdelay, input bit late);
    int   hs;
    int   idx;
    exp_t e;
    idx = int'(a[15:8]);
    ocl_arvalid = 1'b1;
    ocl_araddr  = a;
    wait_hi(1, "arready");
    @(posedge clk); #1;
    ocl_arvalid = 1'b0;
    hs = cyc;
    if (vec != '0) begin
      e = '{EV_RSTB, hs, vec, a[7:0], '0};
      q.push_back(e);
    end
    e = '{EV_R, hs + lat, '0, '0, exp_data};
    q.push_back(e);
    if (d > 0) begin
      repeat (d) @(posedge clk);
      #1;
      reg_rvalid[idx]          = 1'b1;
      reg_rdata[idx*32 +: 32]  = rd;
      @(posedge clk); #1;
      reg_rvalid[idx] = 1'b0;
    end
    @(negedge clk);
    wait_hi(4, "rvalid");
    for (int i = 0; i < rdelay; i++) begin
      if (late && i == 0) begin
        reg_rvalid[idx]         = 1'b1;
        reg_rdata[idx*32 +: 32] = 32'h0BAD0BAD;
      end
      @(negedge clk);
      if (late) reg_rvalid[idx] = 1'b0;
    end
    ocl_rready = 1'b1;
    @(posedge clk); #1;
    ocl_rready = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outs(input string pfx);
    check32({pfx, "_ctrl"}, {27'b0, ocl_awready, ocl_arready, ocl_wready, ocl_bvalid, ocl_rvalid}, '0);
    check32({pfx, "_rdata"}, ocl_rdata, '0);
    check32({pfx, "_strobes"}, {reg_wvalid, reg_arvalid}, '0);
    check32({pfx, "_addr"}, {16'b0, reg_waddr, reg_araddr}, '0);
    check32({pfx, "_wdata"}, reg_wdata, '0);
  endtask

  int   hs_m;
  exp_t em;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rstn = 1'b1;
    @(negedge clk);

    do_write(32'h0000_0305, 32'h0000_1234, 16'h0008, 5);
    do_read(32'h0000_0210, 16'h0004, 4, 32'h0000_CAFE, 5, 32'h0000_CAFE, 3, 1'b1);
    do_read(32'h0000_0FFF, 16'h8000, 1, 32'h55AA_1234, 2, 32'h55AA_1234, 0, 1'b0);
    do_read(32'h0000_2000, '0, 0, '0, 1, OCL_BAD_ADDR_DATA, 2, 1'b0);
    do_write(32'h0000_2000, 32'h0000_0077, '0, 0);
    do_write(32'hABCD_0A3C, 32'hFEED_F00D, 16'h0400, 1);
    do_read(32'h0000_0544, 16'h0020, 0, '0, READ_TIMEOUT + 1, OCL_TIMEOUT_DATA, 2, 1'b1);

    reg_rvalid[5]         = 1'b1;
    reg_rdata[5*32 +: 32] = 32'h1111_2222;
    @(negedge clk);
    reg_rvalid[5] = 1'b0;

    ocl_arvalid = 1'b1;
    ocl_araddr  = 32'h0000_0720;
    do_write(32'h0000_0108, 32'hA5A5_0001, 16'h0002, 0);
    do_read(32'h0000_0720, 16'h0080, 2, 32'h0000_7777, 3, 32'h0000_7777, 1, 1'b0);

    ocl_arvalid = 1'b1;
    ocl_araddr  = 32'h0000_0110;
    wait_hi(1, "arready");
    @(posedge clk); #1;
    ocl_arvalid = 1'b0;
    hs_m = cyc;
    em = '{EV_RSTB, hs_m, 16'h0002, 8'h10, '0};
    q.push_back(em);
    repeat (3) @(negedge clk);
    #2;
    rstn = 1'b0;
    reg_rvalid[1]         = 1'b1;
    reg_rdata[1*32 +: 32] = 32'h2468_ACE0;
    #1;
    check_reset_outs("rst_mid");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    reg_rvalid[1] = 1'b0;

    do_write(32'h0000_0101, 32'h0BEE_F00D, 16'h0002, 2);
    do_read(32'h0000_0110, 16'h0002, 3, 32'h1357_9BDF, 4, 32'h1357_9BDF, 1, 1'b0);

    repeat (5) @(negedge clk);
    check32("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000ns expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
